onehot_seq_decoder: RTL and testbench
=====================================

// Module: onehot_seq_decoder
// PURPOSE
//  Parametrised, registered binary-to-one-hot decoder with a built-in index sequencer.
//  Generalises the fixed 3-to-8 decoder to SEL_W inputs and NUM_OUT outputs.
//  Three modes: direct decode, free-running phase ring, and one-shot sweep.
//  Drives CPU timing phases, register-file write selects and the bus-enable strobes.
// PARAMETERS
//  SEL_W       3             index width
//  NUM_OUT     1<<SEL_W      one-hot outputs in use; 2 <= NUM_OUT <= 2**SEL_W
//  ACTIVE_LOW  0             1: out is inverted (the active line is 0, idle is all-ones)
// PORTS
//  clk       in   1        clock; all state updates on the rising edge
//  rst       in   1        asynchronous, active-high reset
//  mode      in   2        00 DIRECT, 01 RUN, 10 SHOT, 11 reserved
//  en        in   1        DIRECT: capture sel. RUN/SHOT: advance the index. 0 = hold.
//  start     in   1        SHOT: begin a sweep from index 0 (ignored while busy)
//  load      in   1        RUN/SHOT: force the index to sel next cycle
//  sel       in   SEL_W    DIRECT decode input / load value
//  out       out  NUM_OUT  registered one-hot (or idle) vector
//  idx       out  SEL_W    index currently decoded on out
//  busy      out  1        high while RUN is active or a SHOT sweep is in progress
//  wrap      out  1        1-cycle pulse: RUN index wrapped NUM_OUT-1 -> 0
//  done      out  1        1-cycle pulse: SHOT sweep completed
//  err       out  1        1-cycle pulse: sel >= NUM_OUT, or mode 11
// BEHAVIOUR
//  Reset (async, any time, mid-sweep included):
//   - state=IDLE; idx=0; busy=wrap=done=err=0.
//   - out is all-inactive: 0, or all-ones if ACTIVE_LOW.
//  Output rule:
//   - out = onehot(idx) only in DIRECT-valid, RUN or SHOT-active; otherwise all-inactive.
//   - Never more than one line is active.
//   - Latency: 1 cycle from the input edge to out.
//  FSM states: IDLE, DIRECT, RUN, SHOT. The mode input is sampled every cycle.
//  Mode transitions:
//   - A mode change moves the FSM to that mode's state on the next edge.
//   - Leaving SHOT before completion aborts it: no done pulse; out is idle.
//  DIRECT:
//   - en=1 and sel<NUM_OUT: idx<=sel; out<=onehot(sel).
//   - en=1 and sel>=NUM_OUT: out<=idle; idx unchanged; err pulse.
//   - en=0: out and idx hold.
//   - busy stays 0.
//  RUN:
//   - Entry: idx=0, out=onehot(0), busy=1.
//   - en=1: idx<=(idx==NUM_OUT-1) ? 0 : idx+1.
//   - wrap is asserted in the same cycle that out shows index 0 after a wrap.
//   - en=0 freezes idx and out.
//  SHOT:
//   - Waits with out idle. start=1 -> idx=0, out=onehot(0), busy=1.
//   - Each en=1 cycle advances idx by 1.
//   - An advance from NUM_OUT-1 instead gives: out idle, busy=0, done pulse, return to waiting.
//   - start while busy is ignored.
//  Load (RUN/SHOT):
//   - load=1 wins over en in the same cycle.
//   - sel<NUM_OUT: idx<=sel.
//   - sel>=NUM_OUT: err pulse; idx unchanged.
//   - In SHOT, load is honoured only while busy.
//  Reserved mode 11: out idle, busy=0, err pulses every cycle the mode is held.
//  Non-power-of-two NUM_OUT: the wrap happens at NUM_OUT-1, never at 2**SEL_W-1.
//  Width rule: idx arithmetic is SEL_W bits; the overflow compare is done on SEL_W+1 bits.
// STRUCTURE
//  Shared package cpu_pkg:
//   - mode encodings MODE_DIRECT/RUN/SHOT/RSVD.
//   - FSM state typedef.
//   - onehot(idx,NUM_OUT) function.
//  Sub-module onehot_enc:
//   - combinational SEL_W -> NUM_OUT decode with a valid flag.
//   - reused by the register-file write-select logic.
//  Top level: FSM, index counter, pulse registers and the ACTIVE_LOW output inversion.
// TESTING (SEL_W=3, NUM_OUT=6 unless noted)
//  1 Reset: rst asserted mid-RUN at idx=4 -> immediately out=0, idx=0, busy=0.
//    No clock edge is needed.
//  2 DIRECT: sel=0..5 with en=1 -> out=000001..100000, one cycle later.
//    sel=6 -> out=0 with an err pulse.
//    en=0 -> out holds.
//  3 RUN with en=1 for 8 cycles -> idx 0,1,2,3,4,5,0,1.
//    wrap is 1 only on the second idx=0.
//    en low for 2 cycles -> out frozen.
//  4 SHOT: start, then en=1 for 6 cycles -> out walks 000001..100000, then idle.
//    done pulse; busy falls.
//    A start issued mid-sweep is ignored.
//  5 Load: RUN at idx=1, load=1, sel=4, en=1 -> idx=4 (load wins).
//    load with sel=7 -> err pulse, idx holds.
//  6 ACTIVE_LOW=1, NUM_OUT=8, DIRECT sel=2 -> out=11111011.
//    Reset -> out=11111111.
//    mode=11 -> err pulse each cycle, out=11111111.

Source files
------------

// File: rtl/onehot_seq_decoder_pkg.sv
// Shared types and helpers for the one-hot sequencing decoder: mode encodings,
// FSM state type and a generic one-hot builder.
package onehot_seq_decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_RUN    = 2'b01,
    MODE_SHOT   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_RUN,
    ST_SHOT
  } state_e;

  localparam int MAX_OUT = 256;

  // Callers size-cast the result down to their own NUM_OUT width.
  function automatic logic [MAX_OUT-1:0] onehot(input int idx, input int numOut);
    logic [MAX_OUT-1:0] vec;
    vec = '0;
    if (idx >= 0 && idx < numOut && idx < MAX_OUT) vec[idx[7:0]] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/onehot_seq_decoder_if.sv
// Control and status bundle between a sequencer client (master) and the
// one-hot decoder (slave).
interface onehot_seq_decoder_if
  import onehot_seq_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 1 << SEL_W
);

  mode_e              mode;
  logic               en;
  logic               start;
  logic               load;
  logic [SEL_W-1:0]   sel;
  logic [NUM_OUT-1:0] out;
  logic [SEL_W-1:0]   idx;
  logic               busy;
  logic               wrap;
  logic               done;
  logic               err;

  modport master (
    output mode, en, start, load, sel,
    input  out, idx, busy, wrap, done, err
  );

  modport slave (
    input  mode, en, start, load, sel,
    output out, idx, busy, wrap, done, err
  );

endinterface

// File: rtl/onehot_seq_decoder_enc.sv
// Combinational SEL_W -> NUM_OUT one-hot encoder with a range-valid flag;
// also used by the register-file write-select path.
module onehot_enc #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 1 << SEL_W
) (
  input  logic [SEL_W-1:0]   sel_i,
  output logic [NUM_OUT-1:0] dec_o,
  output logic               valid_o
);

  // Range check on SEL_W+1 bits so NUM_OUT == 2**SEL_W does not overflow.
  always_comb begin
    dec_o   = '0;
    valid_o = ({1'b0, sel_i} < (SEL_W+1)'(NUM_OUT));
    for (int i = 0; i < NUM_OUT; i++) begin
      dec_o[i] = (sel_i == SEL_W'(i));
    end
  end

endmodule

// File: rtl/onehot_seq_decoder.sv
// Registered one-hot decoder with direct, free-running ring and one-shot sweep
// modes; drives timing phases, write selects and bus-enable strobes.
module onehot_seq_decoder
  import onehot_seq_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 1 << SEL_W,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_seq_decoder_if.slave  bus
);

  state_e             state_q;
  logic [SEL_W-1:0]   idx_q;
  logic [NUM_OUT-1:0] hot_q;
  logic               busy_q;
  logic               wrap_q;
  logic               done_q;
  logic               err_q;

  logic [NUM_OUT-1:0] selHot;
  logic               selValid;
  logic               atLast;
  logic [SEL_W-1:0]   idx_d;
  logic [NUM_OUT-1:0] incHot;

  onehot_enc #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_enc (
    .sel_i   (bus.sel),
    .dec_o   (selHot),
    .valid_o (selValid)
  );

  // Ring wraps at NUM_OUT-1, not at the natural SEL_W rollover.
  always_comb begin
    atLast = ({1'b0, idx_q} == (SEL_W+1)'(NUM_OUT - 1));
    idx_d  = atLast ? '0 : idx_q + SEL_W'(1);
    incHot = NUM_OUT'(onehot(32'(idx_d), NUM_OUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hot_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (bus.mode)
        MODE_DIRECT: begin
          state_q <= ST_DIRECT;
          busy_q  <= 1'b0;
          if (bus.en) begin
            if (selValid) begin
              idx_q <= bus.sel;
              hot_q <= selHot;
            end else begin
              hot_q <= '0;
              err_q <= 1'b1;
            end
          end else if (state_q != ST_DIRECT) begin
            hot_q <= '0;
          end
        end
        MODE_RUN: begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
          if (state_q != ST_RUN) begin
            idx_q <= '0;
            hot_q <= NUM_OUT'(1);
          end else if (bus.load) begin
            if (selValid) begin
              idx_q <= bus.sel;
              hot_q <= selHot;
            end else begin
              err_q <= 1'b1;
            end
          end else if (bus.en) begin
            idx_q  <= idx_d;
            hot_q  <= incHot;
            wrap_q <= atLast;
          end
        end
        MODE_SHOT: begin
          state_q <= ST_SHOT;
          // On entry, and after a finished sweep, wait idle for start.
          if (state_q != ST_SHOT) begin
            busy_q <= 1'b0;
            hot_q  <= '0;
          end else if (!busy_q) begin
            if (bus.start) begin
              idx_q  <= '0;
              hot_q  <= NUM_OUT'(1);
              busy_q <= 1'b1;
            end
          end else if (bus.load) begin
            if (selValid) begin
              idx_q <= bus.sel;
              hot_q <= selHot;
            end else begin
              err_q <= 1'b1;
            end
          end else if (bus.en) begin
            if (atLast) begin
              hot_q  <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx_q <= idx_d;
              hot_q <= incHot;
            end
          end
        end
        MODE_RSVD: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          hot_q   <= '0;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out  = ACTIVE_LOW ? ~hot_q : hot_q;
  assign bus.idx  = idx_q;
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Directed bench: a 6-output active-high decoder for the mode tests and an
// 8-output active-low decoder for the inversion/reserved-mode tests.
module tb_onehot_seq_decoder;
  import onehot_seq_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passCount = 0;
  int   checkCount = 0;

  always #5 clk = ~clk;

  onehot_seq_decoder_if #(.SEL_W(3), .NUM_OUT(6)) bus6 ();
  onehot_seq_decoder_if #(.SEL_W(3), .NUM_OUT(8)) bus8 ();

  onehot_seq_decoder #(.SEL_W(3), .NUM_OUT(6), .ACTIVE_LOW(1'b0)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  onehot_seq_decoder #(.SEL_W(3), .NUM_OUT(8), .ACTIVE_LOW(1'b1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input mode_e m, input logic e, input logic s, input logic l,
                               input logic [2:0] sv);
    bus6.mode  = m;
    bus6.en    = e;
    bus6.start = s;
    bus6.load  = l;
    bus6.sel   = sv;
  endtask

  initial begin
    int runSeq[8];
    runSeq = '{0, 1, 2, 3, 4, 5, 0, 1};

    rst = 1'b1;
    applyStimulus(MODE_DIRECT, 1'b0, 1'b0, 1'b0, 3'd0);
    bus8.mode  = MODE_DIRECT;
    bus8.en    = 1'b0;
    bus8.start = 1'b0;
    bus8.load  = 1'b0;
    bus8.sel   = 3'd0;
    #2;
    checkOutput("reset out", 32'(bus6.out), 32'h0);
    checkOutput("reset idx", 32'(bus6.idx), 32'd0);
    checkOutput("reset busy", 32'(bus6.busy), 32'd0);
    checkOutput("reset err", 32'(bus6.err), 32'd0);
    tick();
    rst = 1'b0;

    // DIRECT decode of every legal index, then out-of-range and hold.
    for (int s = 0; s < 6; s++) begin
      applyStimulus(MODE_DIRECT, 1'b1, 1'b0, 1'b0, 3'(s));
      tick();
      checkOutput($sformatf("direct out sel=%0d", s), 32'(bus6.out), 32'd1 << s);
      checkOutput($sformatf("direct idx sel=%0d", s), 32'(bus6.idx), 32'(s));
    end
    applyStimulus(MODE_DIRECT, 1'b1, 1'b0, 1'b0, 3'd6);
    tick();
    checkOutput("direct sel=6 out", 32'(bus6.out), 32'h0);
    checkOutput("direct sel=6 err", 32'(bus6.err), 32'd1);
    checkOutput("direct sel=6 idx", 32'(bus6.idx), 32'd5);
    applyStimulus(MODE_DIRECT, 1'b1, 1'b0, 1'b0, 3'd2);
    tick();
    checkOutput("direct sel=2 out", 32'(bus6.out), 32'h4);
    checkOutput("direct err clears", 32'(bus6.err), 32'd0);
    applyStimulus(MODE_DIRECT, 1'b0, 1'b0, 1'b0, 3'd5);
    tick();
    tick();
    checkOutput("direct hold out", 32'(bus6.out), 32'h4);
    checkOutput("direct hold idx", 32'(bus6.idx), 32'd2);
    checkOutput("direct busy", 32'(bus6.busy), 32'd0);

    // RUN ring over 6 outputs; wrap only on the return to index 0.
    applyStimulus(MODE_RUN, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("run idx step %0d", i), 32'(bus6.idx), 32'(runSeq[i]));
      checkOutput($sformatf("run out step %0d", i), 32'(bus6.out), 32'd1 << runSeq[i]);
      checkOutput($sformatf("run wrap step %0d", i), 32'(bus6.wrap), (i == 6) ? 32'd1 : 32'd0);
    end
    checkOutput("run busy", 32'(bus6.busy), 32'd1);
    applyStimulus(MODE_RUN, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    tick();
    checkOutput("run freeze idx", 32'(bus6.idx), 32'd1);
    checkOutput("run freeze out", 32'(bus6.out), 32'h2);

    // Load beats en; an out-of-range load only raises err.
    applyStimulus(MODE_RUN, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    checkOutput("load idx", 32'(bus6.idx), 32'd4);
    checkOutput("load out", 32'(bus6.out), 32'h10);
    applyStimulus(MODE_RUN, 1'b0, 1'b0, 1'b1, 3'd7);
    tick();
    checkOutput("load sel=7 err", 32'(bus6.err), 32'd1);
    checkOutput("load sel=7 idx", 32'(bus6.idx), 32'd4);

    // Asynchronous reset mid-RUN, checked before any clock edge.
    applyStimulus(MODE_RUN, 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b1;
    #2;
    checkOutput("async rst out", 32'(bus6.out), 32'h0);
    checkOutput("async rst idx", 32'(bus6.idx), 32'd0);
    checkOutput("async rst busy", 32'(bus6.busy), 32'd0);
    tick();

    // SHOT: wait idle, sweep, ignore a mid-sweep start, finish with done.
    applyStimulus(MODE_SHOT, 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    tick();
    checkOutput("shot wait out", 32'(bus6.out), 32'h0);
    checkOutput("shot wait busy", 32'(bus6.busy), 32'd0);
    applyStimulus(MODE_SHOT, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    checkOutput("shot start out", 32'(bus6.out), 32'h1);
    checkOutput("shot start busy", 32'(bus6.busy), 32'd1);
    for (int k = 1; k < 6; k++) begin
      applyStimulus(MODE_SHOT, 1'b1, (k == 3), 1'b0, 3'd0);
      tick();
      checkOutput($sformatf("shot idx step %0d", k), 32'(bus6.idx), 32'(k));
      checkOutput($sformatf("shot out step %0d", k), 32'(bus6.out), 32'd1 << k);
      checkOutput($sformatf("shot done step %0d", k), 32'(bus6.done), 32'd0);
    end
    applyStimulus(MODE_SHOT, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    checkOutput("shot end out", 32'(bus6.out), 32'h0);
    checkOutput("shot end busy", 32'(bus6.busy), 32'd0);
    checkOutput("shot end done", 32'(bus6.done), 32'd1);
    applyStimulus(MODE_SHOT, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    checkOutput("shot done pulse", 32'(bus6.done), 32'd0);

    // Abort: leave SHOT mid-sweep.
    applyStimulus(MODE_SHOT, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    applyStimulus(MODE_SHOT, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    checkOutput("abort pre idx", 32'(bus6.idx), 32'd1);
    applyStimulus(MODE_DIRECT, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    checkOutput("abort out", 32'(bus6.out), 32'h0);
    checkOutput("abort busy", 32'(bus6.busy), 32'd0);
    checkOutput("abort done", 32'(bus6.done), 32'd0);

    // Active-low, 8 outputs.
    bus8.mode = MODE_DIRECT;
    bus8.en   = 1'b1;
    bus8.sel  = 3'd2;
    tick();
    checkOutput("al direct sel=2", 32'(bus8.out), 32'hFB);
    rst = 1'b1;
    #2;
    checkOutput("al reset out", 32'(bus8.out), 32'hFF);
    tick();
    rst = 1'b0;
    bus8.mode = MODE_RSVD;
    bus8.en   = 1'b0;
    tick();
    checkOutput("al rsvd err 1", 32'(bus8.err), 32'd1);
    checkOutput("al rsvd out", 32'(bus8.out), 32'hFF);
    checkOutput("al rsvd busy", 32'(bus8.busy), 32'd0);
    tick();
    checkOutput("al rsvd err 2", 32'(bus8.err), 32'd1);
    bus8.mode = MODE_DIRECT;
    tick();
    checkOutput("al rsvd exit err", 32'(bus8.err), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
